conv_3x3_weight_streamer: RTL and testbench

- Transmit side of the 3x3 weight-buffer interface. Accepts one 3x3 kernel (9 parallel words) at a time from the weight source.
- Serializes each kernel into a contiguous 9-word valid burst for the weight buffer's serial input.
- Tracks how many kernels are stored in the buffer and issues `load_weights` pulses when the conv engine requests the next kernel.

---
 rtl/conv_3x3_weight_streamer_pkg.sv | 14 +
 rtl/conv_3x3_weight_credit_counter.sv | 58 +++++
 rtl/conv_3x3_weight_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_conv_3x3_weight_streamer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_3x3_weight_streamer_pkg.sv
// rtl/conv_3x3_weight_streamer_pkg.sv - shared constants and FSM encoding for the 3x3 weight streamer
package conv_3x3_weight_streamer_pkg;

    localparam int KERNEL_SIZE    = 9;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_K = 2'd1,
        ST_SEND   = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

endpackage

// File: rtl/conv_3x3_weight_credit_counter.sv
// rtl/conv_3x3_weight_credit_counter.sv - stored-kernel credit tracking and load_weights strobe
module conv_3x3_weight_credit_counter #(
    parameter int FIFO_DEPTH   = 16,
    parameter int CREDIT_WIDTH = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic in_flight_set_i,
    input  logic burst_end_i,
    input  logic weight_req_i,
    output logic load_weights_o,
    output logic space_next_o
);

    localparam logic [CREDIT_WIDTH:0]   DEPTH_C = (CREDIT_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] ONE_C   = CREDIT_WIDTH'(1);

    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    in_flight_q, in_flight_d;
    logic                    load_q, load_d;

    always_comb begin
        credit_d = credit_q;
        if (burst_end_i && !load_q) begin
            credit_d = credit_q + ONE_C;
        end else if (!burst_end_i && load_q) begin
            credit_d = credit_q - ONE_C;
        end

        in_flight_d = in_flight_q;
        if (in_flight_set_i) begin
            in_flight_d = 1'b1;
        end else if (burst_end_i) begin
            in_flight_d = 1'b0;
        end

        // The !load_q term keeps strobes at least one cycle apart while the decrement lands.
        load_d = weight_req_i && (credit_q != '0) && !load_q;
    end

    // Look-ahead so the registered kernel_ready reflects next cycle's occupancy.
    assign space_next_o = ({1'b0, credit_d} + {{CREDIT_WIDTH{1'b0}}, in_flight_d}) < DEPTH_C;

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q    <= '0;
            in_flight_q <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            in_flight_q <= in_flight_d;
            load_q      <= load_d;
        end
    end

    assign load_weights_o = load_q;

endmodule

// File: rtl/conv_3x3_weight_streamer.sv
// rtl/conv_3x3_weight_streamer.sv - serializes parallel 3x3 kernels into 9-word bursts for the weight buffer
module conv_3x3_weight_streamer
    import conv_3x3_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH_KERNELS = 10,
    parameter int FIFO_DEPTH        = 16,
    parameter int CREDIT_WIDTH      = 5,
    parameter int INTER_KERNEL_GAP  = 1,
    parameter int GAP_CNT_WIDTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_WIDTH_KERNELS-1:0] num_kernels,
    input  logic                         kernel_valid,
    input  logic [DATA_WIDTH-1:0]        kernel_in_00,
    input  logic [DATA_WIDTH-1:0]        kernel_in_01,
    input  logic [DATA_WIDTH-1:0]        kernel_in_02,
    input  logic [DATA_WIDTH-1:0]        kernel_in_03,
    input  logic [DATA_WIDTH-1:0]        kernel_in_04,
    input  logic [DATA_WIDTH-1:0]        kernel_in_05,
    input  logic [DATA_WIDTH-1:0]        kernel_in_06,
    input  logic [DATA_WIDTH-1:0]        kernel_in_07,
    input  logic [DATA_WIDTH-1:0]        kernel_in_08,
    output logic                         kernel_ready,
    input  logic                         weight_req,
    output logic [DATA_WIDTH-1:0]        out,
    output logic                         valid_out,
    output logic                         load_weights,
    output logic                         busy,
    output logic                         done
);

    localparam logic [3:0]                   LAST_IDX = 4'(KERNEL_SIZE - 1);
    localparam logic [GAP_CNT_WIDTH-1:0]     GAP_LAST = GAP_CNT_WIDTH'(INTER_KERNEL_GAP - 1);
    localparam logic [CNT_WIDTH_KERNELS-1:0] ONE_K    = CNT_WIDTH_KERNELS'(1);
    localparam logic [GAP_CNT_WIDTH-1:0]     ONE_G    = GAP_CNT_WIDTH'(1);

    state_e                         state_q, state_d;
    logic [CNT_WIDTH_KERNELS-1:0]   num_q, num_d;
    logic [CNT_WIDTH_KERNELS-1:0]   sent_q, sent_d;
    logic [3:0]                     idx_q, idx_d;
    logic [GAP_CNT_WIDTH-1:0]       gap_q, gap_d;
    logic                           last_word_q, last_word_d;
    logic [DATA_WIDTH-1:0]          words_q [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]          words_in [KERNEL_SIZE];

    logic [DATA_WIDTH-1:0]          out_q, out_d;
    logic                           valid_q, valid_d;
    logic                           kr_q, kr_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic                           accept;
    logic                           start_ok;
    logic                           space_next;

    assign words_in[0] = kernel_in_00;
    assign words_in[1] = kernel_in_01;
    assign words_in[2] = kernel_in_02;
    assign words_in[3] = kernel_in_03;
    assign words_in[4] = kernel_in_04;
    assign words_in[5] = kernel_in_05;
    assign words_in[6] = kernel_in_06;
    assign words_in[7] = kernel_in_07;
    assign words_in[8] = kernel_in_08;

    // busy_q still high while the final word is on the bus keeps a new start out until done.
    assign start_ok    = (state_q == ST_IDLE) && start && !busy_q;
    assign accept      = (state_q == ST_WAIT_K) && kernel_valid && kr_q;
    assign last_word_d = (state_q == ST_SEND) && (idx_q == LAST_IDX);

    conv_3x3_weight_credit_counter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_credit (
        .clk             (clk),
        .reset           (reset),
        .in_flight_set_i (last_word_d),
        .burst_end_i     (last_word_q),
        .weight_req_i    (weight_req),
        .load_weights_o  (load_weights),
        .space_next_o    (space_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            sent_q      <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            last_word_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            sent_q      <= sent_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            last_word_q <= last_word_d;
        end
    end

    // Word 00 leaves straight from the input on acceptance, so SEND starts at index 1.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        sent_d  = sent_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok && (num_kernels != '0)) begin
                    num_d   = num_kernels;
                    sent_d  = '0;
                    state_d = ST_WAIT_K;
                end
            end
            ST_WAIT_K: begin
                if (accept) begin
                    idx_d   = 4'd1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (idx_q == LAST_IDX) begin
                    sent_d = sent_q + ONE_K;
                    gap_d  = '0;
                    if ((sent_q + ONE_K) == num_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_WAIT_K;
                end else begin
                    gap_d = gap_q + ONE_G;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        kr_d    = (state_d == ST_WAIT_K) && space_next;
        if (start_ok) begin
            if (num_kernels != '0) begin
                busy_d = 1'b1;
            end else begin
                done_d = 1'b1;
            end
        end
        if (accept) begin
            out_d   = kernel_in_00;
            valid_d = 1'b1;
        end
        if (state_q == ST_SEND) begin
            out_d   = words_q[idx_q];
            valid_d = 1'b1;
        end
        if (last_word_q && (state_q == ST_IDLE)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            words_q <= words_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            kr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            kr_q    <= kr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out          = out_q;
    assign valid_out    = valid_q;
    assign kernel_ready = kr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_conv_3x3_weight_streamer.sv
// tb/tb_conv_3x3_weight_streamer.sv - directed self-checking bench for conv_3x3_weight_streamer
module tb_conv_3x3_weight_streamer;
    import conv_3x3_weight_streamer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, start2, kernel_valid, weight_req, weight_req2;
    logic [9:0]  num_kernels;
    logic [31:0] kin [9];
    logic [31:0] out_w, out_w2;
    logic        valid_out, load_weights, kernel_ready, busy, done;
    logic        valid_out2, load_weights2, kernel_ready2, busy2, done2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          c;
        logic [31:0] d;
    } vrec_t;
    vrec_t vq[$];
    int    dq[$];
    int    lq[$];
    int    busy_cnt = 0;
    int    v2 = 0, l2 = 0, d2 = 0;

    always #5 clk = ~clk;

    conv_3x3_weight_streamer dut (
        .clk(clk), .reset(reset), .start(start), .num_kernels(num_kernels),
        .kernel_valid(kernel_valid),
        .kernel_in_00(kin[0]), .kernel_in_01(kin[1]), .kernel_in_02(kin[2]),
        .kernel_in_03(kin[3]), .kernel_in_04(kin[4]), .kernel_in_05(kin[5]),
        .kernel_in_06(kin[6]), .kernel_in_07(kin[7]), .kernel_in_08(kin[8]),
        .kernel_ready(kernel_ready), .weight_req(weight_req), .out(out_w),
        .valid_out(valid_out), .load_weights(load_weights), .busy(busy), .done(done)
    );

    conv_3x3_weight_streamer #(.FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .num_kernels(num_kernels),
        .kernel_valid(kernel_valid),
        .kernel_in_00(kin[0]), .kernel_in_01(kin[1]), .kernel_in_02(kin[2]),
        .kernel_in_03(kin[3]), .kernel_in_04(kin[4]), .kernel_in_05(kin[5]),
        .kernel_in_06(kin[6]), .kernel_in_07(kin[7]), .kernel_in_08(kin[8]),
        .kernel_ready(kernel_ready2), .weight_req(weight_req2), .out(out_w2),
        .valid_out(valid_out2), .load_weights(load_weights2), .busy(busy2), .done(done2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) vq.push_back('{cyc, out_w});
        if (done) dq.push_back(cyc);
        if (load_weights) lq.push_back(cyc);
        if (busy) busy_cnt = busy_cnt + 1;
        if (valid_out2) v2 = v2 + 1;
        if (load_weights2) l2 = l2 + 1;
        if (done2) d2 = d2 + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_kernel(input logic [31:0] base);
        for (int i = 0; i < 9; i++) kin[i] = base + 32'(i);
    endtask

    task automatic pulse_start(input logic [9:0] n);
        num_kernels = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k = 0;
        while (!done && k < max) begin
            tick();
            k++;
        end
        check(tag, done, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
    endtask

    int vb, db, lb, v2b, l2b, d2b, bb, c0, k;
    logic seen;

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; kernel_valid = 1'b0;
        weight_req = 1'b0; weight_req2 = 1'b0; num_kernels = '0;
        set_kernel(32'h0);
        tick(3);
        reset = 1'b0;
        tick();
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_kready", kernel_ready, 0);
        check("rst_load", load_weights, 0);
        check("rst_out", out_w, 0);
        check("rst_credit", dut.u_credit.credit_q, 0);

        // single kernel
        vb = vq.size(); db = dq.size();
        set_kernel(32'h10); kernel_valid = 1'b1;
        pulse_start(10'd1);
        wait_done("t1_done_timeout", 30);
        tick(2);
        kernel_valid = 1'b0;
        check("t1_nwords", vq.size() - vb, 9);
        for (int i = 0; i < 9; i++) check($sformatf("t1_word%0d", i), vq[vb+i].d, 32'h10 + i);
        check("t1_contig", vq[vb+8].c - vq[vb].c, 8);
        check("t1_ndone", dq.size() - db, 1);
        check("t1_done_time", dq[db] - vq[vb+8].c, 1);
        check("t1_credit", dut.u_credit.credit_q, 1);
        check("t1_busy", busy, 0);

        // three kernels, kernel_valid held
        do_reset();
        vb = vq.size(); db = dq.size();
        set_kernel(32'h20); kernel_valid = 1'b1;
        pulse_start(10'd3);
        wait_done("t2_done_timeout", 60);
        tick(2);
        check("t2_nwords", vq.size() - vb, 27);
        check("t2_gap1", vq[vb+9].c - vq[vb+8].c, 2);
        check("t2_gap2", vq[vb+18].c - vq[vb+17].c, 2);
        check("t2_burst2_contig", vq[vb+17].c - vq[vb+9].c, 8);
        check("t2_span", vq[vb+26].c - vq[vb].c, 28);
        check("t2_first_b3", vq[vb+18].d, 32'h20);
        check("t2_last_b3", vq[vb+26].d, 32'h28);
        check("t2_ndone", dq.size() - db, 1);
        check("t2_credit", dut.u_credit.credit_q, 3);

        // FIFO_DEPTH = 2 back-pressure
        v2b = v2; l2b = l2; d2b = d2;
        set_kernel(32'h30); kernel_valid = 1'b1; num_kernels = 10'd3;
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick(40);
        check("t3_two_bursts", v2 - v2b, 18);
        check("t3_kready_low", kernel_ready2, 0);
        check("t3_credit_full", dut2.u_credit.credit_q, 2);
        check("t3_busy", busy2, 1);
        weight_req2 = 1'b1;
        seen = 1'b0; k = 0;
        while (!seen && k < 10) begin
            tick(); k++;
            if (load_weights2) seen = 1'b1;
        end
        weight_req2 = 1'b0;
        check("t3_load_seen", seen, 1);
        k = 0;
        while (!done2 && k < 40) begin
            tick(); k++;
        end
        check("t3_done_seen", done2, 1);
        tick(2);
        check("t3_nwords", v2 - v2b, 27);
        check("t3_nloads", l2 - l2b, 1);
        check("t3_ndone", d2 - d2b, 1);
        check("t3_credit", dut2.u_credit.credit_q, 2);

        // weight_req held with no credit
        do_reset();
        vb = vq.size(); lb = lq.size();
        weight_req = 1'b1;
        set_kernel(32'h40);
        pulse_start(10'd1);
        wait_done("t4_done_timeout", 30);
        tick(5);
        check("t4_nloads", lq.size() - lb, 1);
        check("t4_load_time", lq[lb] - vq[vb+8].c, 2);
        check("t4_credit", dut.u_credit.credit_q, 0);
        weight_req = 1'b0;

        // load strobe coincides with burst end
        set_kernel(32'h50);
        pulse_start(10'd1);
        wait_done("t5a_done_timeout", 30);
        tick(2);
        check("t5_credit_pre", dut.u_credit.credit_q, 1);
        set_kernel(32'h60);
        pulse_start(10'd1);
        k = 0;
        while (!(valid_out && out_w == 32'h67) && k < 30) begin
            tick(); k++;
        end
        weight_req = 1'b1;
        tick();
        weight_req = 1'b0;
        check("t5_load_now", load_weights, 1);
        check("t5_last_word_now", out_w, 32'h68);
        tick(3);
        check("t5_credit_post", dut.u_credit.credit_q, 1);

        // reset mid-burst
        set_kernel(32'h70);
        pulse_start(10'd2);
        k = 0;
        while (!(valid_out && out_w == 32'h74) && k < 30) begin
            tick(); k++;
        end
        reset = 1'b1;
        tick();
        check("t6_valid", valid_out, 0);
        check("t6_busy", busy, 0);
        check("t6_credit", dut.u_credit.credit_q, 0);
        check("t6_kready", kernel_ready, 0);
        check("t6_state", dut.state_q, ST_IDLE);
        vb = vq.size(); db = dq.size();
        reset = 1'b0;
        tick(20);
        check("t6_no_valid", vq.size() - vb, 0);
        check("t6_no_done", dq.size() - db, 0);

        // zero-kernel job
        kernel_valid = 1'b0;
        vb = vq.size(); db = dq.size(); bb = busy_cnt;
        c0 = cyc;
        pulse_start(10'd0);
        tick(4);
        check("t7_ndone", dq.size() - db, 1);
        check("t7_done_time", dq[db] - c0, 1);
        check("t7_no_valid", vq.size() - vb, 0);
        check("t7_no_busy", busy_cnt - bb, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
